// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse tone sequencer.
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TONE     = 3'd1,
      GAP      = 3'd2,
      CHAR_GAP = 3'd3,
      WORD_GAP = 3'd4
   } state_t;

   localparam int unsigned DOT_UNITS      = 1;
   localparam int unsigned DASH_UNITS     = 3;
   localparam int unsigned ELEM_GAP_UNITS = 1;
   localparam int unsigned CHAR_GAP_UNITS = 3;
   localparam int unsigned WORD_GAP_UNITS = 4;

   // DDS increment per Hz of output tone
   localparam int unsigned HZ_TO_INCR     = 91626;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; o_expire_c is high for the single cycle the loaded count reaches 0.
module morse_unit_timer #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expire_c
);

   logic [W-1:0] r_cnt;
   logic         r_run;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_clear) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
         r_run <= 1'b1;
      end else if (r_run) begin
         if (r_cnt == '0) r_run <= 1'b0;
         else             r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expire_c = r_run & (r_cnt == '0);

endmodule

// File: rtl/morse_tone_sequencer.sv
// Plays one dot/dash character at a time as DDS tone on/off with Morse timing.
// Optional word gap on iLEN == 0 is enabled by defining MORSE_WORD_GAP_EN.
module morse_tone_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 6000000,
   parameter logic [31:0] TONE_INCR   = 32'(830 * HZ_TO_INCR),
   parameter int unsigned MAX_ELEM    = 6
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iVALID,
   output logic                oREADY,
   input  logic [MAX_ELEM-1:0] iPATTERN,
   input  logic [2:0]          iLEN,
   input  logic                iABORT,
   output logic [31:0]         oDDS_INCR,
   output logic                oTONE_EN,
   output logic                oBUSY,
   output logic                oDONE
);

`ifdef MORSE_WORD_GAP_EN
   localparam int unsigned MAX_UNITS = WORD_GAP_UNITS;
`else
   localparam int unsigned MAX_UNITS = CHAR_GAP_UNITS;
`endif
   localparam int unsigned TW = $clog2(MAX_UNITS * UNIT_CYCLES);

   localparam logic [TW-1:0] DOT_LD  = TW'(DOT_UNITS * UNIT_CYCLES - 1);
   localparam logic [TW-1:0] DASH_LD = TW'(DASH_UNITS * UNIT_CYCLES - 1);
   localparam logic [TW-1:0] ELEM_LD = TW'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
   localparam logic [TW-1:0] CHAR_LD = TW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
   localparam logic [TW-1:0] WORD_LD = TW'(WORD_GAP_UNITS * UNIT_CYCLES - 1);
`endif

   state_t                r_state;
   logic [MAX_ELEM-1:0]   r_shift;
   logic [2:0]            r_elem_cnt;
   logic                  r_tone;
   logic [31:0]           r_incr;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_expire;
   logic                  w_load;
   logic [TW-1:0]         w_load_val;
   logic [2:0]            w_len;

   assign oREADY   = (r_state == IDLE) & ~iABORT;
   assign w_accept = iVALID & oREADY;
   assign w_len    = (32'(iLEN) > MAX_ELEM) ? 3'(MAX_ELEM) : iLEN;

   // Timer reload at every state entry that starts a new duration
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_len != 3'd0) begin
                  w_load     = 1'b1;
                  w_load_val = iPATTERN[0] ? DASH_LD : DOT_LD;
               end
`ifdef MORSE_WORD_GAP_EN
               else begin
                  w_load     = 1'b1;
                  w_load_val = WORD_LD;
               end
`endif
            end
         end
         TONE: begin
            if (w_expire) begin
               w_load     = 1'b1;
               w_load_val = (r_elem_cnt == 3'd1) ? CHAR_LD : ELEM_LD;
            end
         end
         GAP: begin
            if (w_expire) begin
               w_load     = 1'b1;
               w_load_val = r_shift[0] ? DASH_LD : DOT_LD;
            end
         end
         default: ;
      endcase
   end

   morse_unit_timer #(.W(TW)) u_timer (
      .i_clk      (iCLK),
      .i_rst_n    (iRST_N),
      .i_clear    (iABORT),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expire_c (w_expire)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_elem_cnt <= '0;
         r_tone     <= 1'b0;
         r_incr     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (iABORT) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_elem_cnt <= '0;
            r_tone     <= 1'b0;
            r_incr     <= '0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_accept) begin
                     if (w_len != 3'd0) begin
                        r_state    <= TONE;
                        r_shift    <= iPATTERN;
                        r_elem_cnt <= w_len;
                        r_tone     <= 1'b1;
                        r_incr     <= TONE_INCR;
                        r_busy     <= 1'b1;
                     end else begin
`ifdef MORSE_WORD_GAP_EN
                        r_state <= WORD_GAP;
                        r_busy  <= 1'b1;
`else
                        r_done  <= 1'b1;
`endif
                     end
                  end
               end
               TONE: begin
                  if (w_expire) begin
                     r_elem_cnt <= r_elem_cnt - 3'd1;
                     r_shift    <= r_shift >> 1;
                     r_tone     <= 1'b0;
                     r_incr     <= '0;
                     r_state    <= (r_elem_cnt == 3'd1) ? CHAR_GAP : GAP;
                  end
               end
               GAP: begin
                  if (w_expire) begin
                     r_state <= TONE;
                     r_tone  <= 1'b1;
                     r_incr  <= TONE_INCR;
                  end
               end
               CHAR_GAP, WORD_GAP: begin
                  if (w_expire) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign oDDS_INCR = r_incr;
   assign oTONE_EN  = r_tone;
   assign oBUSY     = r_busy;
   assign oDONE     = r_done;

endmodule

// File: tb/tb_morse_tone_sequencer.sv
// Randomized bench: per-cycle expected output stream built from Morse timing rules.
module tb_morse_tone_sequencer;

   localparam int unsigned U  = 4;
   localparam logic [31:0] TI = 32'd76049580;

   logic        iCLK;
   logic        iRST_N;
   logic        iVALID;
   logic        oREADY;
   logic [5:0]  iPATTERN;
   logic [2:0]  iLEN;
   logic        iABORT;
   logic [31:0] oDDS_INCR;
   logic        oTONE_EN;
   logic        oBUSY;
   logic        oDONE;

   int n_vec;
   int n_err;
   // 0 = busy silence, 1 = tone, 2 = done cycle, 3 = quiet idle
   int exp_q[$];

   morse_tone_sequencer #(.UNIT_CYCLES(U), .TONE_INCR(TI), .MAX_ELEM(6)) dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .iVALID    (iVALID),
      .oREADY    (oREADY),
      .iPATTERN  (iPATTERN),
      .iLEN      (iLEN),
      .iABORT    (iABORT),
      .oDDS_INCR (oDDS_INCR),
      .oTONE_EN  (oTONE_EN),
      .oBUSY     (oBUSY),
      .oDONE     (oDONE)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_cycle(input string tag, input int code);
      check({tag, ".tone"},  32'(oTONE_EN),  32'(code == 1));
      check({tag, ".incr"},  oDDS_INCR,      (code == 1) ? TI : 32'd0);
      check({tag, ".busy"},  32'(oBUSY),     32'(code < 2));
      check({tag, ".done"},  32'(oDONE),     32'(code == 2));
      check({tag, ".ready"}, 32'(oREADY),    32'(code >= 2));
   endtask

   task automatic build(input logic [5:0] pat, input logic [2:0] len);
      int n;
      n = (len > 3'd6) ? 6 : int'(len);
      exp_q.delete();
      if (n == 0) begin
`ifdef MORSE_WORD_GAP_EN
         repeat (4 * U) exp_q.push_back(0);
`endif
         exp_q.push_back(2);
      end else begin
         for (int i = 0; i < n; i++) begin
            repeat ((pat[i] ? 3 : 1) * U) exp_q.push_back(1);
            if (i < n - 1) repeat (U) exp_q.push_back(0);
         end
         repeat (3 * U) exp_q.push_back(0);
         exp_q.push_back(2);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
   task automatic send(input string tag, input logic [5:0] pat, input logic [2:0] len,
                       input bit keep);
      build(pat, len);
      iVALID   = 1'b1;
      iPATTERN = pat;
      iLEN     = len;
      @(posedge iCLK); #1;
      iVALID   = keep;
      iPATTERN = 6'($urandom);
      iLEN     = 3'($urandom);
      foreach (exp_q[i]) begin
         @(negedge iCLK);
         check_cycle(tag, exp_q[i]);
      end
      iVALID = 1'b0;
   endtask

   task automatic send_abort(input string tag, input logic [5:0] pat, input logic [2:0] len,
                             input int k);
      build(pat, len);
      iVALID   = 1'b1;
      iPATTERN = pat;
      iLEN     = len;
      @(posedge iCLK); #1;
      iVALID   = 1'b0;
      for (int i = 0; i < k; i++) begin
         @(negedge iCLK);
         check_cycle(tag, exp_q[i]);
      end
      iABORT = 1'b1;
      @(posedge iCLK); #1;
      iABORT = 1'b0;
      repeat (4 * U + 2) begin
         @(negedge iCLK);
         check_cycle({tag, ".post"}, 3);
      end
   endtask

   initial begin
      logic [5:0] pat;
      logic [2:0] len;
      n_vec    = 0;
      n_err    = 0;
      iRST_N   = 1'b0;
      iVALID   = 1'b0;
      iPATTERN = '0;
      iLEN     = '0;
      iABORT   = 1'b0;
      #1;
      check_cycle("reset", 3);
      repeat (3) @(negedge iCLK);
      iRST_N = 1'b1;
      @(negedge iCLK);
      check_cycle("idle", 3);

      send("E", 6'b000000, 3'd1, 1'b0);
      send("A", 6'b000010, 3'd2, 1'b0);
      send_abort("abortT", 6'b000001, 3'd1, 6);

      // Accept and abort in the same cycle: abort wins
      iVALID = 1'b1; iPATTERN = 6'h15; iLEN = 3'd3; iABORT = 1'b1;
      #1 check("abort_accept.ready", 32'(oREADY), 32'd0);
      @(posedge iCLK); #1;
      iVALID = 1'b0; iABORT = 1'b0;
      repeat (3) begin
         @(negedge iCLK);
         check_cycle("abort_accept", 3);
      end

      send("b2b1", 6'b000001, 3'd1, 1'b1);
      send("b2b2", 6'b000110, 3'd3, 1'b0);
      send("len0", 6'h2A, 3'd0, 1'b0);
      send("len7", 6'h3F, 3'd7, 1'b0);
      @(negedge iCLK);
      check_cycle("len7.after", 3);

      // Asynchronous reset in the middle of a tone
      iVALID = 1'b1; iPATTERN = 6'h01; iLEN = 3'd1;
      @(posedge iCLK); #1;
      iVALID = 1'b0;
      repeat (2) begin
         @(negedge iCLK);
         check_cycle("pre_rst", 1);
      end
      #2 iRST_N = 1'b0;
      #1 check_cycle("mid_rst", 3);
      @(negedge iCLK);
      iRST_N = 1'b1;
      @(negedge iCLK);
      check_cycle("post_rst", 3);

      for (int t = 0; t < 30; t++) begin
         pat = 6'($urandom);
         len = 3'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            if (len == 3'd0) len = 3'd1;
            build(pat, len);
            send_abort("rnd_abort", pat, len, $urandom_range(1, exp_q.size() - 1));
         end else begin
            send("rnd", pat, len, 1'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
